sliding_window_kxk: RTL
=======================

# sliding_window_kxk

Parametrised K×K sliding-window generator feeding the convolution engines: consumes a raster-order pixel stream (one pixel of CH channels per beat) and emits every full K×K window at the configured stride, flattened into one vector. It generalises the fixed 5×5 single-channel line buffer with:
- configurable kernel size, image size, channel count and stride;
- ready/valid backpressure on both sides;
- frame-aware counters with an end-of-frame marker.

## Interface
Parameters:
- DATA_BITS, 8, bits per channel sample
- IMG_W, 28, pixels per row (≥ K)
- IMG_H, 28, rows per frame (≥ K)
- K, 5, window side (2..7)
- CH, 1, channels per pixel
- STRIDE, 1, window step in x and y (1..K)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_data  in  CH*DATA_BITS  input pixel; channel 0 in MSBs
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts s_data this cycle
- m_win  out  K*K*CH*DATA_BITS  flattened window
- m_valid  out  1  m_win valid
- m_ready  in  1  consumer accepts m_win
- m_last  out  1  qualifies final window of the frame

## Operation
- A pixel is accepted on a cycle with s_valid && s_ready.
- Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) track the accepted pixel.
  - x wraps to 0 after IMG_W-1 and y increments.
  - After (IMG_W-1, IMG_H-1), both return to 0: the next pixel starts a new frame.
- Storage:
  - K-1 row delays of IMG_W entries each.
  - A K×K register array shifted left by one column per accepted pixel; the new column is loaded from the row delays plus the incoming pixel.
- A window is complete when the accepted pixel has x ≥ K-1 and y ≥ K-1, and (x-(K-1)) and (y-(K-1)) are multiples of STRIDE.
  - Stride alignment uses phase counters, not modulo.
  - No window is emitted until K rows of the current frame have arrived; stale rows from the previous frame are never emitted.
- Window layout:
  - Tap t = r*K + c, where r=0 is the oldest row and c=0 the oldest column.
  - Tap t occupies m_win[(K*K-1-t)*CH*DATA_BITS +: CH*DATA_BITS].
  - Channel ch within a tap occupies [(CH-1-ch)*DATA_BITS +: DATA_BITS].
  - Tap 0 (top-left) is in the MSBs.
- m_last = 1 with the window whose bottom-right pixel is (IMG_W-1, IMG_H-1) when that position is stride-aligned; otherwise with the last aligned window of the frame.
- Windows per frame: ((IMG_W-K)/STRIDE+1)*((IMG_H-K)/STRIDE+1), integer division.

## Timing
- One-deep output register; s_ready = !m_valid || m_ready.
- Latency: a completing pixel accepted in cycle n gives m_valid=1 in cycle n+1.
- Holding the output:
  - m_valid, m_win and m_last are held stable while m_valid && !m_ready.
  - m_valid drops the cycle after the handshake unless a new window completes in the same cycle.
- Throughput: one pixel per cycle when m_ready is held high.
- Gaps in s_valid do not affect window contents or order.
- Reset (any time, including mid-frame):
  - Next cycle: m_valid=0, m_last=0, m_win=0, x=y=0, phase counters 0, s_ready=1.
  - Row-delay contents are not cleared; they are never emitted before being refilled.

## Structure
- Shared package cnn_pkg holds:
  - function win_count(IMG_W, IMG_H, K, STRIDE);
  - localparam helpers for counter widths ($clog2(IMG_W), $clog2(IMG_H)).
- One sub-module, row_delay: a single-port, IMG_W-deep, CH*DATA_BITS-wide read-before-write delay line, advanced only on accepted pixels.
  - Instantiated K-1 times and chained.

## Test plan
- **Default config, continuous stream.** K=5, 28×28, CH=1, STRIDE=1; pixel value = (y*28+x) mod 256; m_ready=1.
  - Exactly 576 windows.
  - First window appears one cycle after pixel 116 is accepted: tap0=0, tap24=116.
  - 576th window: tap24=783 mod 256=15, with m_last=1.
- **Stride 2.** K=3, IMG_W=IMG_H=8, STRIDE=2, pixel=y*8+x.
  - 9 windows; bottom-right taps in order 18, 20, 22, 34, …, 54.
  - m_last only on 54.
- **Backpressure.** Hold m_ready=0 for 10 cycles while m_valid=1.
  - m_win is constant and s_ready=0 throughout.
  - After release, the window sequence is identical to the unstalled run.
- **Random s_valid gaps** (50% duty), default config.
  - Window sequence and m_last position are bit-identical to the continuous run.
- **Reset mid-frame.** Assert rst after 300 pixels.
  - m_valid=0 next cycle.
  - A fresh frame yields 576 correct windows with no stale data.
- **Multi-channel packing.** CH=3, K=3, 8×8; channel c value = 64*c + y*8+x.
  - Every tap's three channels land in the specified slices.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared helpers for the convolution front-end blocks.
//               - win_count : number of K x K windows per frame at a stride
//               - cnt_w     : counter width for a range 0..n-1 (minimum 1 bit)
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    // Largest kernel side the window generator is built for.
    localparam int c_MAX_K = 7;

    function automatic int win_count(input int img_w, input int img_h,
                                     input int k, input int stride);
        return ((img_w - k) / stride + 1) * ((img_h - k) / stride + 1);
    endfunction

    // Width of a counter covering 0..n-1; a 1-value range still needs a bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/sliding_window_kxk_row_delay.sv
`default_nettype none
// ============================================================================
// Module      : row_delay
// Description : Single-port, DEPTH-deep, read-before-write delay line. Every
//               enabled cycle returns the word written DEPTH enables earlier
//               and overwrites that slot with the new word.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_en          - advance the line (accepted pixel)
//               i_data        - word to store
//               o_data        - word stored DEPTH enables ago
// Revision    : 1.0 - initial release
// ============================================================================
module row_delay
    import cnn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    localparam int c_AW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_ptr;

    // Read happens at the slot about to be overwritten, so the output is
    // valid combinationally in the same cycle the new word is presented.
    assign o_data = r_mem[r_ptr];

    // The pointer is reset so it stays in lock-step with the column counter;
    // the storage itself is not cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == c_AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_data;
        end
    end

endmodule : row_delay
`default_nettype wire

// File: rtl/sliding_window_kxk.sv
`default_nettype none
// ============================================================================
// Module      : sliding_window_kxk
// Description : K x K sliding-window generator over a raster pixel stream.
//               Emits every stride-aligned full window, flattened with tap 0
//               (oldest row, oldest column) in the MSBs, plus an end-of-frame
//               marker on the last window of each frame.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               s_data/valid/ready - input pixel stream (channel 0 in MSBs)
//               m_win/valid/ready  - flattened window output
//               m_last             - final window of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module sliding_window_kxk
    import cnn_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int K         = 5,
    parameter int CH        = 1,
    parameter int STRIDE    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CH*DATA_BITS-1:0]     s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [K*K*CH*DATA_BITS-1:0] m_win,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last
);

    localparam int c_PW = CH * DATA_BITS;
    localparam int c_XW = cnt_w(IMG_W);
    localparam int c_YW = cnt_w(IMG_H);
    localparam int c_SW = cnt_w(STRIDE);

    // Bottom-right corner of the last stride-aligned window of a frame.
    localparam logic [c_XW-1:0] c_LAST_X = c_XW'(K - 1 + ((IMG_W - K) / STRIDE) * STRIDE);
    localparam logic [c_YW-1:0] c_LAST_Y = c_YW'(K - 1 + ((IMG_H - K) / STRIDE) * STRIDE);

    logic [c_XW-1:0] r_x;
    logic [c_YW-1:0] r_y;
    logic [c_SW-1:0] r_xph;
    logic [c_SW-1:0] r_yph;
    logic [c_PW-1:0] r_win [K][K];
    logic            r_valid;
    logic            r_last;

    logic            w_accept;
    logic            w_x_in;
    logic            w_y_in;
    logic            w_x_end;
    logic            w_y_end;
    logic            w_done;
    logic [c_SW-1:0] w_xph_inc;
    logic [c_SW-1:0] w_yph_inc;
    logic [c_PW-1:0] w_rd_out [K-1];
    logic [c_PW-1:0] w_col    [K];

    assign s_ready  = !r_valid || m_ready;
    assign w_accept = s_valid && s_ready;
    assign w_x_in   = (r_x >= c_XW'(K - 1));
    assign w_y_in   = (r_y >= c_YW'(K - 1));
    assign w_x_end  = (r_x == c_XW'(IMG_W - 1));
    assign w_y_end  = (r_y == c_YW'(IMG_H - 1));

    assign w_xph_inc = (r_xph == c_SW'(STRIDE - 1)) ? '0 : r_xph + 1'b1;
    assign w_yph_inc = (r_yph == c_SW'(STRIDE - 1)) ? '0 : r_yph + 1'b1;

    // Phase 0 in both axes marks a stride-aligned bottom-right corner. Since
    // y restarts at 0 each frame, requiring y >= K-1 keeps any previous
    // frame's rows still sitting in the delay lines out of the output.
    assign w_done = w_accept && w_x_in && w_y_in && (r_xph == '0) && (r_yph == '0);

    // Chained row delays: output i holds the pixel i+1 rows above.
    for (genvar i = 0; i < K - 1; i++) begin : g_rd
        logic [c_PW-1:0] w_rd_in;
        if (i == 0) begin : g_first
            assign w_rd_in = s_data;
        end else begin : g_chain
            assign w_rd_in = w_rd_out[i-1];
        end
        row_delay #(
            .WIDTH (c_PW),
            .DEPTH (IMG_W)
        ) u_row_delay (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_accept),
            .i_data (w_rd_in),
            .o_data (w_rd_out[i])
        );
    end

    // New column: row 0 is the oldest (deepest delay), row K-1 the live pixel.
    for (genvar r = 0; r < K; r++) begin : g_col
        if (r == K - 1) begin : g_live
            assign w_col[r] = s_data;
        end else begin : g_delayed
            assign w_col[r] = w_rd_out[K-2-r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_xph <= '0;
            r_yph <= '0;
        end else if (w_accept) begin
            if (w_x_end) begin
                r_x   <= '0;
                r_xph <= '0;
                if (w_y_end) begin
                    r_y   <= '0;
                    r_yph <= '0;
                end else begin
                    r_y <= r_y + 1'b1;
                    if (w_y_in) begin
                        r_yph <= w_yph_inc;
                    end
                end
            end else begin
                r_x <= r_x + 1'b1;
                if (w_x_in) begin
                    r_xph <= w_xph_inc;
                end
            end
        end
    end

    // The window array doubles as the output register: it only shifts on an
    // accepted pixel, and no pixel is accepted while a window is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_col[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_done) begin
            r_valid <= 1'b1;
            r_last  <= (r_x == c_LAST_X) && (r_y == c_LAST_Y);
        end else if (m_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_out_r
        for (genvar c = 0; c < K; c++) begin : g_out_c
            assign m_win[(K*K-1-(r*K+c))*c_PW +: c_PW] = r_win[r][c];
        end
    end

    assign m_valid = r_valid;
    assign m_last  = r_last;

endmodule : sliding_window_kxk
`default_nettype wire
